// File: rtl/param_loader.sv
// param_loader: frame-based loader for the filter parameter register bank (n, h, w, r).
//
// Receives a byte stream over valid/ready and buffers one frame.
//   Default frame:                 HEADER, n, h, w, r
//   With PARAM_CHECKSUM_EN:        HEADER, n, h, w, r, chk   (chk == n^h^w^r)
// A frame is accepted when n != 0 and r < n (unsigned); h and w are not checked.
// An accepted frame is committed to the bank as four writes on consecutive cycles
// (sel 00..11 -> n, h, w, r). A rejected frame pulses err and writes nothing.
//
// Optional feature macro: PARAM_CHECKSUM_EN (adds the chk byte and the CHK state).
//
// Ports
//   clk        in   system clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   s_data     in   stream byte
//   s_valid    in   s_data valid
//   s_ready    out  byte accepted when s_valid & s_ready at posedge
//   sel        out  bank select: 00=n, 01=h, 10=w, 11=r
//   w_en       out  bank write strobe, one cycle per word
//   wr_data    out  word written to the bank
//   busy       out  high in every state except IDLE
//   done       out  1-cycle pulse: frame committed
//   err        out  1-cycle pulse: frame rejected
//   cfg_valid  out  sticky, set by the first done, cleared only by reset
module param_loader #(
  parameter int unsigned           INPUT_SIZE = 8,
  parameter logic [INPUT_SIZE-1:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INPUT_SIZE-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [1:0]            sel,
  output logic                  w_en,
  output logic [INPUT_SIZE-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cfg_valid
);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
`ifdef PARAM_CHECKSUM_EN
    StChk,
`endif
    StCommit,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [INPUT_SIZE-1:0] buf_q [4];
  logic [INPUT_SIZE-1:0] buf_d [4];
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            sel_q, sel_d;
  logic                  w_en_q, w_en_d;
  logic [INPUT_SIZE-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cfg_valid_q, cfg_valid_d;

  logic                  rdy_state;
  logic                  xfer;
  logic [1:0]            sel_nxt;

  function automatic logic frame_ok(input logic [INPUT_SIZE-1:0] n,
                                    input logic [INPUT_SIZE-1:0] r);
    return (n != '0) && (r < n);
  endfunction

  always_comb begin
    rdy_state = 1'b0;
    unique case (state_q)
      StIdle, StRecv: rdy_state = 1'b1;
`ifdef PARAM_CHECKSUM_EN
      StChk:          rdy_state = 1'b1;
`endif
      default:        rdy_state = 1'b0;
    endcase
  end

  // rst_n gates s_ready directly so nothing is accepted while reset is held.
  assign s_ready = rst_n & rdy_state;
  assign xfer    = s_valid & s_ready;
  assign sel_nxt = sel_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    w_en_d      = 1'b0;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cfg_valid_d = cfg_valid_q;

    unique case (state_q)
      StIdle: begin
        // Non-header bytes are dropped silently.
        if (xfer && (s_data == HEADER)) begin
          state_d = StRecv;
          idx_d   = 2'd0;
        end
      end

      StRecv: begin
        if (xfer) begin
          buf_d[idx_q] = s_data;
          idx_d        = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef PARAM_CHECKSUM_EN
            state_d = StChk;
`else
            // r is still on s_data this cycle; buf_q[3] is not yet written.
            if (frame_ok(buf_q[0], s_data)) begin
              state_d   = StCommit;
              sel_d     = 2'd0;
              w_en_d    = 1'b1;
              wr_data_d = buf_q[0];
            end else begin
              state_d = StErr;
              err_d   = 1'b1;
            end
`endif
          end
        end
      end

`ifdef PARAM_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          if (frame_ok(buf_q[0], buf_q[3]) &&
              (s_data == (buf_q[0] ^ buf_q[1] ^ buf_q[2] ^ buf_q[3]))) begin
            state_d   = StCommit;
            sel_d     = 2'd0;
            w_en_d    = 1'b1;
            wr_data_d = buf_q[0];
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`endif

      StCommit: begin
        if (sel_q == 2'd3) begin
          state_d     = StDone;
          done_d      = 1'b1;
          cfg_valid_d = 1'b1;
        end else begin
          sel_d     = sel_nxt;
          w_en_d    = 1'b1;
          wr_data_d = buf_q[sel_nxt];
        end
      end

      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      idx_q       <= 2'd0;
      sel_q       <= 2'd0;
      w_en_q      <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      w_en_q      <= w_en_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign sel       = sel_q;
  assign w_en      = w_en_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cfg_valid = cfg_valid_q;
  assign busy      = (state_q != StIdle);

endmodule
